// File: rtl/regfile_pkg.sv
// Shared constants and the per-read-port source select for register_file_mp.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int PC_INDEX       = 15;
  localparam int PC_READ_OFFSET = 8;
  // Addresses are zero-extended to this width before entering rd_select.
  localparam int SEL_AW         = 16;

  typedef enum logic [1:0] {
    SEL_STORED = 2'd0,
    SEL_WR0    = 2'd1,
    SEL_WR1    = 2'd2,
    SEL_PC     = 2'd3
  } rd_sel_e;

  // PC view beats forwarding; port 0 forwarding beats port 1.
  function automatic rd_sel_e rd_select(
    input logic [SEL_AW-1:0] raddr,
    input logic [SEL_AW-1:0] pc_addr,
    input logic              bypass,
    input logic              we0,
    input logic [SEL_AW-1:0] a0,
    input logic              we1,
    input logic [SEL_AW-1:0] a1
  );
    rd_sel_e sel;
    sel = SEL_STORED;
    if (raddr == pc_addr)                 sel = SEL_PC;
    else if (bypass && we0 && a0 == raddr) sel = SEL_WR0;
    else if (bypass && we1 && a1 == raddr) sel = SEL_WR1;
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: reservation sets a bit, any write to that register clears it.
// A same-cycle set wins over clear, since the new producer supersedes the old one.
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         set_en,
  input  logic [ADDR_WIDTH-1:0]        set_addr,
  input  logic                         clr0_en,
  input  logic [ADDR_WIDTH-1:0]        clr0_addr,
  input  logic                         clr1_en,
  input  logic [ADDR_WIDTH-1:0]        clr1_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] lookup_addr,
  output logic [NUM_READ-1:0]          busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] pending;

  for (genvar i = 0; i < DEPTH; i++) begin : g_bit
    logic set_hit, clr_hit;
    assign set_hit = set_en && (set_addr == ADDR_WIDTH'(i));
    assign clr_hit = (clr0_en && (clr0_addr == ADDR_WIDTH'(i))) ||
                     (clr1_en && (clr1_addr == ADDR_WIDTH'(i)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pending[i] <= 1'b0;
      else if (set_hit) pending[i] <= 1'b1;
      else if (clr_hit) pending[i] <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_lookup
    assign busy[k] = pending[lookup_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two prioritised write ports, combinational reads with
// optional write-first bypass, PC read view, PC-write notification and hazard scoreboard.
import regfile_pkg::*;

module register_file_mp #(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int NUM_READ       = 3,
  parameter int PC_INDEX       = regfile_pkg::PC_INDEX,
  parameter int PC_READ_OFFSET = regfile_pkg::PC_READ_OFFSET,
  parameter int BYPASS         = 1
) (
  input  logic                           clock,
  input  logic                           resetN,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] readData,
  output logic [NUM_READ-1:0]            readBusy,
  input  logic [DATA_WIDTH-1:0]          pcIn,
  input  logic                           isWrite0,
  input  logic [ADDR_WIDTH-1:0]          A3_0,
  input  logic [DATA_WIDTH-1:0]          writeData0,
  input  logic                           isWrite1,
  input  logic [ADDR_WIDTH-1:0]          A3_1,
  input  logic [DATA_WIDTH-1:0]          writeData1,
  input  logic                           reserveEn,
  input  logic [ADDR_WIDTH-1:0]          reserveAddr,
  output logic                           pcWriteEn,
  output logic [DATA_WIDTH-1:0]          pcWriteData
);

  localparam int                    DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_INDEX);
  localparam logic [DATA_WIDTH-1:0] PC_OFF  = DATA_WIDTH'(PC_READ_OFFSET);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  pc_hit0, pc_hit1;

  assign pc_hit0 = isWrite0 && (A3_0 == PC_ADDR);
  assign pc_hit1 = isWrite1 && (A3_1 == PC_ADDR);

  // Port 1 is assigned first so a colliding port-0 write overrides it.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pcWriteEn   <= 1'b0;
      pcWriteData <= '0;
    end else begin
      if (isWrite1) regs[A3_1] <= writeData1;
      if (isWrite0) regs[A3_0] <= writeData0;
      pcWriteEn <= pc_hit0 || pc_hit1;
      if (pc_hit0)      pcWriteData <= writeData0;
      else if (pc_hit1) pcWriteData <= writeData1;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    rd_sel_e               sel;
    logic [DATA_WIDTH-1:0] rd;

    assign ra  = readAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel = rd_select(SEL_AW'(ra), SEL_AW'(PC_ADDR), BYPASS != 0,
                           isWrite0, SEL_AW'(A3_0), isWrite1, SEL_AW'(A3_1));

    always_comb begin
      rd = regs[ra];
      case (sel)
        SEL_PC:  rd = pcIn + PC_OFF;
        SEL_WR0: rd = writeData0;
        SEL_WR1: rd = writeData1;
        default: rd = regs[ra];
      endcase
    end

    assign readData[k*DATA_WIDTH +: DATA_WIDTH] = rd;
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_scoreboard (
    .clk         (clock),
    .rst_n       (resetN),
    .set_en      (reserveEn),
    .set_addr    (reserveAddr),
    .clr0_en     (isWrite0),
    .clr0_addr   (A3_0),
    .clr1_en     (isWrite1),
    .clr1_addr   (A3_1),
    .lookup_addr (readAddr),
    .busy        (readBusy)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a BYPASS=1 and a BYPASS=0 instance share all inputs
// and are compared against an array-based reference model.
module tb_register_file_mp;

  logic        clock = 1'b0;
  logic        resetN;
  logic [11:0] readAddr;
  logic [95:0] readData, rdata_nb;
  logic [2:0]  readBusy, busy_nb;
  logic [31:0] pcIn;
  logic        isWrite0, isWrite1, reserveEn;
  logic [3:0]  A3_0, A3_1, reserveAddr;
  logic [31:0] writeData0, writeData1;
  logic        pcWriteEn, pcen_nb;
  logic [31:0] pcWriteData, pcdat_nb;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [16];
  bit          pend [16];
  logic        pc_en_m;
  logic [31:0] pc_dat_m;

  always #5 clock = ~clock;

  register_file_mp #(.BYPASS(1)) dut (
    .clock(clock), .resetN(resetN), .readAddr(readAddr), .readData(readData),
    .readBusy(readBusy), .pcIn(pcIn), .isWrite0(isWrite0), .A3_0(A3_0),
    .writeData0(writeData0), .isWrite1(isWrite1), .A3_1(A3_1), .writeData1(writeData1),
    .reserveEn(reserveEn), .reserveAddr(reserveAddr), .pcWriteEn(pcWriteEn),
    .pcWriteData(pcWriteData)
  );

  register_file_mp #(.BYPASS(0)) dut_nb (
    .clock(clock), .resetN(resetN), .readAddr(readAddr), .readData(rdata_nb),
    .readBusy(busy_nb), .pcIn(pcIn), .isWrite0(isWrite0), .A3_0(A3_0),
    .writeData0(writeData0), .isWrite1(isWrite1), .A3_1(A3_1), .writeData1(writeData1),
    .reserveEn(reserveEn), .reserveAddr(reserveAddr), .pcWriteEn(pcen_nb),
    .pcWriteData(pcdat_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] a, input bit byp);
    if (a == 4'd15)                           return pcIn + 32'd8;
    if (byp && isWrite0 && A3_0 == a)         return writeData0;
    if (byp && isWrite1 && A3_1 == a)         return writeData1;
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mem[i] = '0; pend[i] = 1'b0; end
    pc_en_m  = 1'b0;
    pc_dat_m = '0;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] a;
      a = readAddr[k*4 +: 4];
      chk({tag, ".rd"},    readData[k*32 +: 32], exp_read(a, 1'b1));
      chk({tag, ".rd_nb"}, rdata_nb[k*32 +: 32], exp_read(a, 1'b0));
      chk({tag, ".busy"},  {31'd0, readBusy[k]}, {31'd0, pend[a]});
      chk({tag, ".busy_nb"}, {31'd0, busy_nb[k]}, {31'd0, pend[a]});
    end
    chk({tag, ".pcen"},     {31'd0, pcWriteEn}, {31'd0, pc_en_m});
    chk({tag, ".pcdat"},    pcWriteData, pc_dat_m);
    chk({tag, ".pcen_nb"},  {31'd0, pcen_nb}, {31'd0, pc_en_m});
    chk({tag, ".pcdat_nb"}, pcdat_nb, pc_dat_m);
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clock);
    if (resetN) begin
      bit hit0, hit1;
      hit0 = isWrite0 && A3_0 == 4'd15;
      hit1 = isWrite1 && A3_1 == 4'd15;
      pc_en_m = hit0 || hit1;
      if (hit0)      pc_dat_m = writeData0;
      else if (hit1) pc_dat_m = writeData1;
      if (isWrite1) begin mem[A3_1] = writeData1; pend[A3_1] = 1'b0; end
      if (isWrite0) begin mem[A3_0] = writeData0; pend[A3_0] = 1'b0; end
      if (reserveEn) pend[reserveAddr] = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    isWrite0 = 0; isWrite1 = 0; reserveEn = 0;
    A3_0 = 0; A3_1 = 0; reserveAddr = 0;
    writeData0 = 0; writeData1 = 0;
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    readAddr = {a2, a1, a0};
  endtask

  initial begin
    resetN = 1'b0;
    idle_inputs();
    set_rd(0, 1, 4);
    pcIn = 32'h100;
    model_reset();
    #1;
    chk("rst.pcen", {31'd0, pcWriteEn}, 32'd0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;

    // Reset state and PC view
    #1;
    chk("rst.r0", readData[31:0], 32'h0);
    chk("rst.r1", readData[63:32], 32'h0);
    chk("rst.r4", readData[95:64], 32'h0);
    chk("rst.busy", {29'd0, readBusy}, 32'd0);
    set_rd(15, 1, 4); #1;
    chk("pc.view", readData[31:0], 32'h108);
    check_all("rst");

    // Port 0 write with same-cycle bypass
    set_rd(4, 4, 0);
    isWrite0 = 1; A3_0 = 4; writeData0 = 32'h12345678; #1;
    chk("byp.r4", readData[31:0], 32'h12345678);
    chk("nobyp.r4", rdata_nb[31:0], 32'h0);
    check_all("wr4");
    tick(); idle_inputs(); #1;
    chk("stored.r4", readData[31:0], 32'h12345678);
    chk("stored_nb.r4", rdata_nb[31:0], 32'h12345678);

    // Collision on R2
    isWrite0 = 1; A3_0 = 2; writeData0 = 32'hAAAA0000;
    isWrite1 = 1; A3_1 = 2; writeData1 = 32'h5555FFFF;
    set_rd(2, 4, 1); #1;
    chk("coll.byp", readData[31:0], 32'hAAAA0000);
    tick(); idle_inputs(); #1;
    chk("coll.r2", readData[31:0], 32'hAAAA0000);

    // R0 is writable
    isWrite0 = 1; A3_0 = 0; writeData0 = 32'h87654321;
    tick(); idle_inputs(); set_rd(0, 1, 2); #1;
    chk("r0.wr", readData[31:0], 32'h87654321);
    chk("r1.zero", readData[63:32], 32'h0);

    // Scoreboard: reserve, set-beats-clear, clear
    set_rd(7, 7, 7);
    reserveEn = 1; reserveAddr = 7; #1;
    chk("rsv.same", {31'd0, readBusy[0]}, 32'd0);
    tick(); idle_inputs(); #1;
    chk("rsv.busy", {31'd0, readBusy[0]}, 32'd1);
    isWrite0 = 1; A3_0 = 7; writeData0 = 32'h77; reserveEn = 1; reserveAddr = 7;
    tick(); idle_inputs(); #1;
    chk("rsv.setwins", {31'd0, readBusy[1]}, 32'd1);
    isWrite1 = 1; A3_1 = 7; writeData1 = 32'h78; #1;
    chk("rsv.noclrbyp", {31'd0, readBusy[2]}, 32'd1);
    tick(); idle_inputs(); #1;
    chk("rsv.clear", {31'd0, readBusy[0]}, 32'd0);
    check_all("rsv");

    // PC write through port 1, then PC read wrap
    isWrite1 = 1; A3_1 = 15; writeData1 = 32'hDEADBEEF;
    tick(); idle_inputs(); #1;
    chk("pcw.en", {31'd0, pcWriteEn}, 32'd1);
    chk("pcw.dat", pcWriteData, 32'hDEADBEEF);
    tick(); #1;
    chk("pcw.pulse", {31'd0, pcWriteEn}, 32'd0);
    chk("pcw.hold", pcWriteData, 32'hDEADBEEF);
    set_rd(15, 0, 0); pcIn = 32'hFFFFFFFC; #1;
    chk("pc.wrap", readData[31:0], 32'h00000004);

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      isWrite0    = 1'($urandom);
      isWrite1    = 1'($urandom);
      A3_0        = 4'($urandom);
      A3_1        = ($urandom_range(0, 3) == 0) ? A3_0 : 4'($urandom);
      writeData0  = $urandom;
      writeData1  = $urandom;
      reserveEn   = 1'($urandom);
      reserveAddr = ($urandom_range(0, 3) == 0) ? A3_0 : 4'($urandom);
      readAddr    = 12'($urandom);
      pcIn        = $urandom;
      #1;
      check_all("rnd");
      tick();
    end
    idle_inputs(); #1;
    check_all("rnd.end");

    // Mid-operation reset: PC write pending in pcWriteEn, reservation held
    isWrite0 = 1; A3_0 = 15; writeData0 = 32'hCAFEF00D; reserveEn = 1; reserveAddr = 9;
    tick();
    isWrite0 = 1; A3_0 = 3; writeData0 = 32'h33333333; reserveEn = 0;
    set_rd(9, 3, 15); #1;
    chk("pre.pcen", {31'd0, pcWriteEn}, 32'd1);
    chk("pre.busy9", {31'd0, readBusy[0]}, 32'd1);
    #2 resetN = 1'b0; #1;
    model_reset();
    chk("arst.pcen", {31'd0, pcWriteEn}, 32'd0);
    chk("arst.pcdat", pcWriteData, 32'd0);
    chk("arst.busy", {29'd0, readBusy}, 32'd0);
    tick();
    idle_inputs(); resetN = 1'b1; #1;
    chk("arst.r3", readData[63:32], 32'd0);
    check_all("arst");
    set_rd(4, 2, 0); #1;
    chk("arst.r4", readData[31:0], 32'd0);
    check_all("arst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
